// File: rtl/mult_shift_add_core.sv
// mult_shift_add_core
// Sequential shift-and-add unsigned multiplier, one partial-product step per
// clock. The memory-mapped multiplier peripheral feeds op_a, op_b and init;
// firmware polls done and reads result.
//
// Timing: a rising edge of init is seen in IDLE at edge E0. LOAD runs at E1,
// CALC runs at E2..E(WIDTH+1), and result/done update at E(WIDTH+2). The
// latency does not depend on the operand values.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous, active-high reset
//   init      start request (level); only a 0->1 transition seen in IDLE starts
//   op_a      multiplicand A, captured in LOAD
//   op_b      multiplier B, captured in LOAD
//   result    registered product A*B, 2*WIDTH bits
//   done      registered; high from DONE until the next LOAD
//   busy      registered; high from LOAD through the last CALC step
//   state_dbg current FSM state (0=IDLE, 1=LOAD, 2=CALC, 3=DONE)
//
// Handshake: there is no valid/ready pair. A start is a rising edge of init
// while the core is idle. Edges that arrive while the core is busy are dropped
// and are not queued. init_q always follows init, so a level that is held
// high never starts a second operation.
module mult_shift_add_core #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               init_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic               start;
  logic               last_step;

  assign start     = init && !init_q;
  assign last_step = (count == CNT_W'(WIDTH - 1));
  assign state_dbg = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_LOAD;
      S_LOAD: state_next = S_CALC;
      S_CALC: if (last_step) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      init_q <= init;
      case (state)
        S_LOAD: begin
          mcand  <= {{WIDTH{1'b0}}, op_a};
          mplier <= op_b;
          acc    <= '0;
          count  <= '0;
          done   <= 1'b0;
          busy   <= 1'b1;
        end
        S_CALC: begin
          // The accumulator is wide enough that an unsigned product never
          // overflows, so the truncating add loses nothing.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
        end
        S_DONE: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_shift_add_core.sv
module tb_mult_shift_add_core;

  localparam int WIDTH = 16;

  logic              clk;
  logic              rst;
  logic              init;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [31:0]       result;
  logic              done;
  logic              busy;
  logic [1:0]        state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_exp;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[10];

  mult_shift_add_core #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .op_a      (op_a),
    .op_b      (op_b),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete operation. init goes high before edge E0. It is dropped after
  // the tick with index 'hold', or it stays high when hold >= 18.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int hold, input string name);
    int busy_cnt;
    op_a = a;
    op_b = b;
    init = 1'b1;
    tick();  // E0
    busy_cnt = 0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (i == 1) begin
        check({name, " done_low_in_load"}, {31'd0, done}, 32'd0);
        check({name, " result_held_in_load"}, result, last_exp);
      end
      if (i == hold) init = 1'b0;
    end
    check({name, " done_low_at_e17"}, {31'd0, done}, 32'd0);
    tick();  // E18
    check({name, " result"}, result, exp);
    check({name, " done_at_e18"}, {31'd0, done}, 32'd1);
    check({name, " busy_low_at_e18"}, {31'd0, busy}, 32'd0);
    check({name, " busy_cycles"}, busy_cnt, 32'd17);
    last_exp = exp;
  endtask

  initial begin
    vecs[0] = '{16'h0005, 16'h000F, 32'h0000004B, 6};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 2};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000, 2};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000, 2};
    vecs[4] = '{16'h00FF, 16'h0101, 32'h0000FFFF, 2};
    vecs[5] = '{16'h0003, 16'h000F, 32'h0000002D, 2};
    vecs[6] = '{16'hABCD, 16'h1234, 32'h0C374FA4, 2};
    vecs[7] = '{16'h8000, 16'h0002, 32'h00010000, 2};
    vecs[8] = '{16'hFFFF, 16'h0001, 32'h0000FFFF, 2};
    vecs[9] = '{16'h0001, 16'h8000, 32'h00008000, 2};

    rst  = 1'b1;
    init = 1'b0;
    op_a = '0;
    op_b = '0;
    last_exp = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", result, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven vectors
    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].hold, $sformatf("vec%0d", v));
      init = 1'b0;
      tick();
    end

    // Operand change and init toggle during CALC are both ignored
    op_a = 16'h0005;
    op_b = 16'h000F;
    init = 1'b1;
    tick();  // E0
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 4) op_a = 16'h0003;
      if (i == 8) init = 1'b0;
      if (i == 9) init = 1'b1;
    end
    tick();  // E18
    check("midop result", result, 32'h0000004B);
    check("midop done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midop no_restart busy", {31'd0, busy}, 32'd0);
      check("midop no_restart done", {31'd0, done}, 32'd1);
    end
    last_exp = 32'h0000004B;
    init = 1'b0;
    tick();
    run_op(16'h0003, 16'h000F, 32'h0000002D, 2, "after_midop");
    init = 1'b0;
    tick();

    // Reset in the middle of an operation
    op_a = 16'h00FF;
    op_b = 16'h0101;
    init = 1'b1;
    tick();  // E0
    repeat (10) tick();
    rst = 1'b1;
    #1;
    check("midrst result", result, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst state", {30'd0, state_dbg}, 32'd0);
    init = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    last_exp = 32'd0;
    run_op(16'h00FF, 16'h0101, 32'h0000FFFF, 2, "after_rst");
    init = 1'b0;
    tick();

    // init held high across and after a full operation
    run_op(16'h0007, 16'h0009, 32'h0000003F, 100, "hold_high");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold busy", {31'd0, busy}, 32'd0);
      check("hold done", {31'd0, done}, 32'd1);
      check("hold result", result, 32'h0000003F);
    end
    init = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_shift_add_core.md
Name: mult_shift_add_core

Overview:
- Sequential shift-and-add unsigned multiplier.
- Sits directly downstream of the memory-mapped multiplier peripheral. The peripheral drives the operand and init registers into this core, and reads back result and done at the result and done addresses.
- Computes A*B with one partial-product step per clock.
- Latency is fixed and deterministic so firmware can poll done.

Parameters:
WIDTH, 16, operand width in bits; result is 2*WIDTH bits.
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
init  input  1  start request; level from the peripheral's init register, acted on at its rising edge only.
op_a  input  WIDTH  multiplicand A.
op_b  input  WIDTH  multiplier B.
result  output  2*WIDTH  product A*B, registered.
done  output  1  high when result is valid, registered.
busy  output  1  high from LOAD through CALC inclusive.

Behaviour:
- Reset (async, rst=1) clears all state: state=IDLE, init_q=0, result=0, done=0, busy=0, acc=0, mcand=0, mplier=0, count=0.
- Start detect: init_q is a registered copy of init. A start is init=1 && init_q=0, sampled in IDLE only.
- FSM states: IDLE, LOAD, CALC, DONE.
- IDLE:
  - on start, go to LOAD.
  - init held high does not restart; init must return to 0 before the next start.
- LOAD (one cycle):
  - mcand <= zero-extended op_a (2*WIDTH bits); mplier <= op_b; acc <= 0; count <= 0; done <= 0; busy=1.
  - go to CALC.
- CALC (exactly WIDTH cycles, no early exit):
  - if mplier[0] then acc <= acc + mcand.
  - mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
  - when count == WIDTH-1, go to DONE.
- DONE (one cycle):
  - result <= acc; done <= 1; busy <= 0; go to IDLE.
- Latency: init rising edge first sampled at clock edge E0 -> LOAD at E1 -> CALC at E2..E(WIDTH+1) -> result/done updated at E(WIDTH+2). This is 18 cycles for WIDTH=16.
- Hold behaviour:
  - done stays 1 and result holds until the next LOAD.
  - LOAD clears done; result keeps its old value until the next DONE.
- Arithmetic:
  - acc is 2*WIDTH bits; overflow is impossible for unsigned operands.
  - The addition truncates to 2*WIDTH bits with no carry out.
- Operand capture: op_a and op_b are sampled only in LOAD. Changes afterwards have no effect on the running product.
- Start while busy: an init rising edge during LOAD/CALC/DONE is ignored, not queued. init_q still tracks init, so a level held through DONE does not start a new operation.
- Reset mid-operation: immediate return to IDLE with all outputs at 0. The partial product is discarded.
- Zero operands: still take full latency; result = 0.

Test Plan:
- Reset, op_a=0x0005, op_b=0x000F, pulse init high for 7 cycles then low -> busy high for 17 cycles; done=1 with result=0x0000004B exactly 18 edges after init first sampled high.
- op_a=0xFFFF, op_b=0xFFFF, init rise -> result=0xFFFE0001, done=1 at cycle 18; no truncation error.
- op_a=0x1234, op_b=0x0000; then op_a=0x0000, op_b=0xABCD -> each returns result=0 after full 18-cycle latency. done drops during LOAD and rises again.
- Start 5*15, change op_a to 0x0003 at cycle 4, toggle init low/high at cycle 8 -> result=0x4B at cycle 18 and no second operation. With init low after DONE, a new rise starts 3*15 -> result=0x2D.
- Start 0x00FF*0x0101, assert rst at cycle 10 for one cycle -> result=0, done=0, busy=0 immediately. A subsequent init rise yields result=0x0000FFFF after 18 cycles.
- Hold init high continuously after one full operation -> done stays 1, result is stable, and busy never reasserts.
